disp_arbiter: RTL and testbench

Shares the Display_Driver write port (WE/Addr/WD) among three hardware requesters: source 0 (CPU bridge), source 1 (count/timer unit) and source 2 (exception/status reporter). Each granted request becomes a two-beat write sequence: the 32-bit hex word at Addr 0, then the sign nibble at Addr 1. A minimum-hold counter prevents owner flicker, and source 2 preempts everything. The block sits between the requesters and the Display_Driver CPU-side port.

---
 rtl/disp_arbiter.sv | 127 ++++++++++++
 tb/tb_disp_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/disp_arbiter.sv
// rtl/disp_arbiter.sv - three-source arbiter for the Display_Driver write port
// Each grant emits a data beat (Addr 0) then a sign beat (Addr 1); source 2 preempts the hold window.
module disp_arbiter #(
  parameter int HOLD_CYCLES = 1000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [2:0]  Req,
  input  logic [31:0] Data0,
  input  logic [31:0] Data1,
  input  logic [31:0] Data2,
  input  logic [3:0]  Sign0,
  input  logic [3:0]  Sign1,
  input  logic [3:0]  Sign2,
  output logic [2:0]  Ack,
  output logic [1:0]  Owner,
  output logic        Disp_WE,
  output logic        Disp_Addr,
  output logic [31:0] Disp_WD
);

  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {IDLE, WR_DATA, WR_SIGN} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] hold_cnt;
  logic          last;
  logic [31:0]   cap_data;
  logic [3:0]    cap_sign;
  logic [1:0]    win_idx;
  logic [2:0]    elig;
  logic          hold_free;
  logic          grant;
  logic [1:0]    grant_idx;

  // Only a non-owner 0/1 source is held off by the hold window.
  always_comb begin
    hold_free = (hold_cnt == '0);
    elig[0]   = Req[0] & (hold_free | (Owner == 2'd0));
    elig[1]   = Req[1] & (hold_free | (Owner == 2'd1));
    elig[2]   = Req[2];
    grant     = |elig;
  end

  always_comb begin
    grant_idx = 2'd0;
    if (elig[2]) begin
      grant_idx = 2'd2;
    end else if (elig[0] && elig[1]) begin
      grant_idx = last ? 2'd0 : 2'd1;
    end else if (elig[1]) begin
      grant_idx = 2'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = WR_DATA;
      WR_DATA: state_nxt = WR_SIGN;
      WR_SIGN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Disp_WE   = 1'b0;
    Disp_Addr = 1'b0;
    Disp_WD   = 32'd0;
    Ack       = 3'b000;
    case (state)
      WR_DATA: begin
        Disp_WE = 1'b1;
        Disp_WD = cap_data;
      end
      WR_SIGN: begin
        Disp_WE   = 1'b1;
        Disp_Addr = 1'b1;
        Disp_WD   = {28'd0, cap_sign};
        Ack       = 3'b001 << win_idx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      last     <= 1'b1;
      cap_data <= 32'd0;
      cap_sign <= 4'd0;
      win_idx  <= 2'd0;
      Owner    <= 2'b11;
    end else begin
      state <= state_nxt;
      if (state == WR_SIGN) begin
        hold_cnt <= HOLD_LOAD;
        Owner    <= win_idx;
      end else if (!hold_free) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
      // Capture at the grant edge so later Data/Sign changes cannot leak into the sequence.
      if (state == IDLE && grant) begin
        win_idx <= grant_idx;
        case (grant_idx)
          2'd1: begin
            cap_data <= Data1;
            cap_sign <= Sign1;
          end
          2'd2: begin
            cap_data <= Data2;
            cap_sign <= Sign2;
          end
          default: begin
            cap_data <= Data0;
            cap_sign <= Sign0;
          end
        endcase
        if (grant_idx != 2'd2) last <= grant_idx[0];
      end
    end
  end

endmodule

// File: tb/tb_disp_arbiter.sv
// tb/tb_disp_arbiter.sv - self-checking bench for disp_arbiter
// Directed vectors on a HOLD=8 instance and a HOLD=0 instance, then randomized traffic against a model.
module tb_disp_arbiter;

  logic        Clock;
  logic        Reset;
  logic [2:0]  Req;
  logic [31:0] Data0, Data1, Data2;
  logic [3:0]  Sign0, Sign1, Sign2;

  logic [2:0]  a_ack, b_ack;
  logic [1:0]  a_own, b_own;
  logic        a_we, b_we, a_addr, b_addr;
  logic [31:0] a_wd, b_wd;

  int n_tests = 0;
  int n_fail  = 0;

  disp_arbiter #(.HOLD_CYCLES(8)) u_dut (
    .Clock(Clock), .Reset(Reset), .Req(Req),
    .Data0(Data0), .Data1(Data1), .Data2(Data2),
    .Sign0(Sign0), .Sign1(Sign1), .Sign2(Sign2),
    .Ack(a_ack), .Owner(a_own), .Disp_WE(a_we), .Disp_Addr(a_addr), .Disp_WD(a_wd)
  );

  disp_arbiter #(.HOLD_CYCLES(0)) u_dut0 (
    .Clock(Clock), .Reset(Reset), .Req(Req),
    .Data0(Data0), .Data1(Data1), .Data2(Data2),
    .Sign0(Sign0), .Sign1(Sign1), .Sign2(Sign2),
    .Ack(b_ack), .Owner(b_own), .Disp_WE(b_we), .Disp_Addr(b_addr), .Disp_WD(b_wd)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Packed expectation: {we, addr, wd[31:0], ack[2:0], owner[1:0]}
  task automatic chk(input string nm, input int idx, input int which, input logic [38:0] exp);
    logic [38:0] act;
    act = (which == 0) ? {a_we, a_addr, a_wd, a_ack, a_own} : {b_we, b_addr, b_wd, b_ack, b_own};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] dut%0d: got we=%b addr=%b wd=%h ack=%b owner=%0d, want we=%b addr=%b wd=%h ack=%b owner=%0d",
               nm, idx, which, act[38], act[37], act[36:5], act[4:2], act[1:0],
               exp[38], exp[37], exp[36:5], exp[4:2], exp[1:0]);
    end
  endtask

  function automatic logic [38:0] idle_exp(input logic [1:0] own);
    return {1'b0, 1'b0, 32'd0, 3'b000, own};
  endfunction

  // Transaction-level model: beats remaining in the write in flight plus arbitration bookkeeping.
  typedef struct {
    int          beat;
    int          win;
    logic [31:0] data;
    logic [3:0]  sign;
    int          owner;
    int          hold;
    int          last;
  } model_t;

  function automatic model_t minit();
    model_t m;
    m.beat = 0; m.win = 0; m.data = 32'd0; m.sign = 4'd0;
    m.owner = 3; m.hold = 0; m.last = 1;
    return m;
  endfunction

  function automatic model_t mstep(input model_t m, input logic rst_n, input logic [2:0] req,
                                   input logic [2:0][31:0] dd, input logic [2:0][3:0] ss, input int h);
    model_t n;
    bit [2:0] el;
    int w;
    if (!rst_n) return minit();
    n = m;
    n.hold = (m.hold > 0) ? m.hold - 1 : 0;
    if (m.beat == 2) begin
      n.owner = m.win;
      n.hold  = h;
      n.beat  = 0;
    end else if (m.beat == 1) begin
      n.beat = 2;
    end else begin
      for (int k = 0; k < 3; k++) el[k] = req[k] && (m.hold == 0 || k == m.owner || k == 2);
      if (el != 3'b000) begin
        if (el[2]) w = 2;
        else if (el[0] && el[1]) w = 1 - m.last;
        else w = el[1] ? 1 : 0;
        if (w < 2) n.last = w;
        n.win  = w;
        n.data = dd[w];
        n.sign = ss[w];
        n.beat = 1;
      end
    end
    return n;
  endfunction

  function automatic logic [38:0] mexp(input model_t m);
    if (m.beat == 1) return {1'b1, 1'b0, m.data, 3'b000, 2'(m.owner)};
    if (m.beat == 2) return {1'b1, 1'b1, {28'd0, m.sign}, 3'(1 << m.win), 2'(m.owner)};
    return idle_exp(2'(m.owner));
  endfunction

  typedef struct {
    logic [2:0]  req;
    logic [31:0] d0, d1;
    logic [3:0]  s0, s1;
    logic [38:0] exp;
  } vec_t;

  vec_t tv[16];

  task automatic do_reset();
    Req = 3'b000;
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
  endtask

  initial begin
    model_t ma, mb;
    logic [2:0][31:0] dd;
    logic [2:0][3:0]  ss;
    logic [31:0] alt_d[2];
    int seq, ph, src, prv;

    Reset = 1'b0; Req = 3'b000;
    Data0 = 32'd0; Data1 = 32'd0; Data2 = 32'd0;
    Sign0 = 4'd0; Sign1 = 4'd0; Sign2 = 4'd0;

    // Source 0 sequence, then source 1 waits out the 8-cycle hold.
    for (int i = 0; i < 16; i++) begin
      tv[i].d0 = 32'h1234_5678; tv[i].s0 = 4'h1;
      tv[i].d1 = 32'hCAFE_0001; tv[i].s1 = 4'h9;
      tv[i].req = (i >= 3 && i <= 12) ? 3'b010 : 3'b000;
      tv[i].exp = idle_exp((i <= 2) ? 2'd3 : (i <= 13) ? 2'd0 : 2'd1);
    end
    tv[0].req = 3'b001;
    tv[1].req = 3'b001;
    tv[1].exp  = {1'b1, 1'b0, 32'h1234_5678, 3'b000, 2'd3};
    tv[2].exp  = {1'b1, 1'b1, 32'h0000_0001, 3'b001, 2'd3};
    tv[12].exp = {1'b1, 1'b0, 32'hCAFE_0001, 3'b000, 2'd0};
    tv[13].exp = {1'b1, 1'b1, 32'h0000_0009, 3'b010, 2'd0};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      Req = tv[i].req; Data0 = tv[i].d0; Sign0 = tv[i].s0; Data1 = tv[i].d1; Sign1 = tv[i].s1;
      chk("vec", i, 0, tv[i].exp);
      @(negedge Clock);
    end

    // HOLD=0 instance: 0/1 alternate, source 0 first, one sequence per 3 cycles.
    do_reset();
    alt_d[0] = 32'hA0A0_0000; alt_d[1] = 32'hB1B1_0001;
    Data0 = alt_d[0]; Data1 = alt_d[1]; Sign0 = 4'h2; Sign1 = 4'h3; Req = 3'b011;
    for (int k = 0; k < 13; k++) begin
      if (k == 0) begin
        chk("alt", k, 1, idle_exp(2'd3));
      end else begin
        seq = (k - 1) / 3; ph = (k - 1) % 3; src = seq % 2;
        prv = (seq == 0) ? 3 : (seq - 1) % 2;
        if (ph == 0) chk("alt", k, 1, {1'b1, 1'b0, alt_d[src], 3'b000, 2'(prv)});
        else if (ph == 1) chk("alt", k, 1, {1'b1, 1'b1, {28'd0, (src == 0) ? 4'h2 : 4'h3}, 3'(1 << src), 2'(prv)});
        else chk("alt", k, 1, idle_exp(2'(src)));
      end
      @(negedge Clock);
    end

    // Exception preemption inside source 0's hold window.
    do_reset();
    chk("rst_state", 0, 0, idle_exp(2'd3));
    Req = 3'b001; Data0 = 32'h1111_0000; Sign0 = 4'h0;
    @(negedge Clock); chk("pre_a", 0, 0, {1'b1, 1'b0, 32'h1111_0000, 3'b000, 2'd3});
    @(negedge Clock); chk("pre_a", 1, 0, {1'b1, 1'b1, 32'h0, 3'b001, 2'd3}); Req = 3'b000;
    @(negedge Clock); chk("pre_a", 2, 0, idle_exp(2'd0));
    @(negedge Clock); chk("pre_a", 3, 0, idle_exp(2'd0));
    Req = 3'b100; Data2 = 32'hDEAD_BEEF; Sign2 = 4'h8;
    @(negedge Clock); chk("pre_x", 0, 0, {1'b1, 1'b0, 32'hDEAD_BEEF, 3'b000, 2'd0}); Req = 3'b000;
    @(negedge Clock); chk("pre_x", 1, 0, {1'b1, 1'b1, 32'h0000_0008, 3'b100, 2'd0});
    @(negedge Clock); Req = 3'b001;
    for (int i = 0; i < 9; i++) begin
      chk("pre_hold", i, 0, idle_exp(2'd2));
      @(negedge Clock);
    end
    chk("pre_b", 0, 0, {1'b1, 1'b0, 32'h1111_0000, 3'b000, 2'd2});
    @(negedge Clock); chk("pre_b", 1, 0, {1'b1, 1'b1, 32'h0, 3'b001, 2'd2}); Req = 3'b000;

    // Data and Req change after the grant edge do not affect the sequence.
    do_reset();
    Req = 3'b001; Data0 = 32'hAAAA_5555; Sign0 = 4'h3;
    @(negedge Clock); chk("cap", 0, 0, {1'b1, 1'b0, 32'hAAAA_5555, 3'b000, 2'd3});
    Data0 = 32'h0BAD_0BAD; Sign0 = 4'hF; Req = 3'b000;
    @(negedge Clock); chk("cap", 1, 0, {1'b1, 1'b1, 32'h0000_0003, 3'b001, 2'd3});
    @(negedge Clock); chk("cap", 2, 0, idle_exp(2'd0));

    // Reset asserted during WR_DATA, pending request re-granted afterwards.
    do_reset();
    Req = 3'b010; Data1 = 32'h1357_2468; Sign1 = 4'h6;
    @(negedge Clock); chk("mid_rst", 0, 0, {1'b1, 1'b0, 32'h1357_2468, 3'b000, 2'd3});
    Reset = 1'b0;
    #1 chk("mid_rst", 1, 0, idle_exp(2'd3));
    @(negedge Clock); chk("mid_rst", 2, 0, idle_exp(2'd3));
    Reset = 1'b1;
    @(negedge Clock); chk("mid_rst", 3, 0, {1'b1, 1'b0, 32'h1357_2468, 3'b000, 2'd3});
    @(negedge Clock); chk("mid_rst", 4, 0, {1'b1, 1'b1, 32'h0000_0006, 3'b010, 2'd3}); Req = 3'b000;

    // Randomized traffic on both instances against the model.
    do_reset();
    ma = minit(); mb = minit();
    for (int c = 0; c < 3000; c++) begin
      chk("rand", c, 0, mexp(ma));
      chk("rand", c, 1, mexp(mb));
      Reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      Req[0] = ($urandom_range(0, 3) != 0);
      Req[1] = ($urandom_range(0, 3) != 0);
      Req[2] = ($urandom_range(0, 15) == 0);
      Data0 = $urandom; Data1 = $urandom; Data2 = $urandom;
      Sign0 = 4'($urandom); Sign1 = 4'($urandom); Sign2 = 4'($urandom);
      dd = {Data2, Data1, Data0};
      ss = {Sign2, Sign1, Sign0};
      ma = mstep(ma, Reset, Req, dd, ss, 8);
      mb = mstep(mb, Reset, Req, dd, ss, 0);
      @(negedge Clock);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
